// File: rtl/kbd_event_ctrl_if.sv
// Event stream between the keyboard controller and its consumer.
// Ready/valid handshake; an entry moves when evt_valid && evt_ready.
//   evt_valid  master->slave  head entry is presented
//   evt_ready  slave->master  consumer accepts the head entry
//   evt_code   master->slave  {extended, byte} key code of the head entry
//   evt_make   master->slave  1 = press, 0 = release
interface kbd_event_ctrl_if;
  logic       evt_valid;
  logic       evt_ready;
  logic [8:0] evt_code;
  logic       evt_make;

  modport master (output evt_valid, output evt_code, output evt_make, input evt_ready);
  modport slave  (input evt_valid, input evt_code, input evt_make, output evt_ready);
endinterface

// File: rtl/kbd_event_ctrl.sv
// Keyboard event controller: decodes PS/2 set-2 bytes (E0 extended and
// F0 break prefixes, with a prefix timeout) into press/release events,
// queues them in a first-word fall-through FIFO and tracks held flags
// for the four game keys.
// Ports:
//   clk, resetN            clock, asynchronous active-low reset
//   din, din_new           received byte and its one-cycle strobe
//   din_parity_ok          parity status of din
//   evt (master)           event stream: evt_valid/evt_ready/evt_code/evt_make
//   key_held[3:0]          space, left, right, down held flags
//   err_cnt[7:0]           saturating parity-error count
//   evt_ovf                sticky: an event was dropped on a full FIFO
module kbd_event_ctrl #(
  parameter int TIMEOUT_CYCLES = 1_500_000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic [7:0]             din,
  input  logic                   din_new,
  input  logic                   din_parity_ok,
  kbd_event_ctrl_if.master       evt,
  output logic [3:0]             key_held,
  output logic [7:0]             err_cnt,
  output logic                   evt_ovf
);

  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = PW + 1;
  localparam int CW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [8:0] KEY_CODE [4] = '{9'h029, 9'h16B, 9'h174, 9'h172};

  typedef enum logic [1:0] {IDLE, GOT_E0, GOT_F0, GOT_E0F0} state_t;

  state_t        state;
  logic [CW-1:0] tmo_cnt;

  // ---------------- decode ----------------
  logic       accepted;
  logic       is_prefix;
  logic       is_ignored;
  logic       ev_push;
  logic       ev_ext;
  logic       ev_make;
  logic [8:0] ev_code;

  assign accepted   = din_new && din_parity_ok;
  assign is_prefix  = (din == 8'hE0) || (din == 8'hF0);
  // Keyboard status/acknowledge bytes carry no key information.
  assign is_ignored = (din == 8'h00) || (din == 8'hFF) || (din == 8'hAA) ||
                      (din == 8'hFA) || (din == 8'hEE) || (din == 8'hFE);
  assign ev_code    = {ev_ext, din};

  always_comb begin
    ev_push = 1'b0;
    ev_ext  = 1'b0;
    ev_make = 1'b1;
    if (accepted && !is_prefix) begin
      case (state)
        IDLE:     ev_push = !is_ignored;
        GOT_E0:   begin ev_push = 1'b1; ev_ext = 1'b1; end
        GOT_F0:   begin ev_push = 1'b1; ev_make = 1'b0; end
        default:  begin ev_push = 1'b1; ev_ext = 1'b1; ev_make = 1'b0; end
      endcase
    end
  end

  // ---------------- prefix FSM + timeout ----------------
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state   <= IDLE;
      tmo_cnt <= '0;
    end else begin
      // Counter saturates at TMO_LAST; it only needs to re-arm on a new byte.
      if (din_new)
        tmo_cnt <= '0;
      else if (state != IDLE && tmo_cnt != TMO_LAST)
        tmo_cnt <= tmo_cnt + 1'b1;

      if (accepted) begin
        if (din == 8'hE0)
          state <= GOT_E0;
        else if (din == 8'hF0)
          state <= (state == GOT_E0 || state == GOT_E0F0) ? GOT_E0F0 : GOT_F0;
        else
          state <= IDLE;
      end else if (din_new) begin
        state <= IDLE;                      // parity error abandons any prefix
      end else if (state != IDLE && tmo_cnt == TMO_LAST) begin
        state <= IDLE;
      end
    end
  end

  // ---------------- held flags ----------------
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_held
      logic held_q;
      always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)
          held_q <= 1'b0;
        else if (ev_push && ev_code == KEY_CODE[gi])
          held_q <= ev_make;
      end
      assign key_held[gi] = held_q;
    end
  endgenerate

  // ---------------- parity error counter ----------------
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)
      err_cnt <= '0;
    else if (din_new && !din_parity_ok && err_cnt != 8'hFF)
      err_cnt <= err_cnt + 8'd1;
  end

  // ---------------- event FIFO ----------------
  logic [8:0]      mem_code [FIFO_DEPTH];
  logic            mem_make [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   rd_ptr_next;
  logic [CNTW-1:0] count;
  logic [CNTW-1:0] count_after_pop;
  logic [CNTW-1:0] count_next;
  logic            pop;
  logic            push_ok;

  assign pop             = evt.evt_valid && evt.evt_ready;
  // Depth is a power of two, so the top count bit alone means "full".
  assign push_ok         = ev_push && (!count[PW] || pop);
  assign rd_ptr_next     = rd_ptr + PW'(pop);
  assign count_after_pop = count - CNTW'(pop);
  assign count_next      = count_after_pop + CNTW'(push_ok);

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_code[wr_ptr] <= ev_code;
      mem_make[wr_ptr] <= ev_make;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      evt_ovf       <= 1'b0;
      evt.evt_valid <= 1'b0;
      evt.evt_code  <= '0;
      evt.evt_make  <= 1'b0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + 1'b1;
      rd_ptr <= rd_ptr_next;
      count  <= count_next;
      if (ev_push && !push_ok)
        evt_ovf <= 1'b1;
      // Registered head: when the queue would otherwise be empty the new
      // entry bypasses the memory; when it stays empty the last head holds.
      evt.evt_valid <= (count_next != '0);
      if (count_next != '0) begin
        if (count_after_pop == '0) begin
          evt.evt_code <= ev_code;
          evt.evt_make <= ev_make;
        end else begin
          evt.evt_code <= mem_code[rd_ptr_next];
          evt.evt_make <= mem_make[rd_ptr_next];
        end
      end
    end
  end

endmodule

// File: tb/tb_kbd_event_ctrl.sv
// Testbench for kbd_event_ctrl: directed byte sequences; expected events
// go into a queue and a negedge monitor checks every handshake.
module tb_kbd_event_ctrl;
  localparam int TMO   = 20;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [8:0] code;
    logic       make;
  } ev_t;

  logic       clk = 1'b0;
  logic       resetN;
  logic [7:0] din;
  logic       din_new;
  logic       din_parity_ok;
  logic [3:0] key_held;
  logic [7:0] err_cnt;
  logic       evt_ovf;

  kbd_event_ctrl_if evt_if ();

  kbd_event_ctrl #(.TIMEOUT_CYCLES(TMO), .FIFO_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .resetN        (resetN),
    .din           (din),
    .din_new       (din_new),
    .din_parity_ok (din_parity_ok),
    .evt           (evt_if.master),
    .key_held      (key_held),
    .err_cnt       (err_cnt),
    .evt_ovf       (evt_ovf)
  );

  always #5 clk = ~clk;

  int  n_cmp = 0;
  int  n_bad = 0;
  ev_t exp_q[$];
  ev_t mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Scoreboard monitor: a handshake seen at negedge completes at the next posedge.
  always @(negedge clk) begin
    if (resetN === 1'b1 && evt_if.evt_valid === 1'b1 && evt_if.evt_ready === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_event: got code %03h make %0b required none",
                 evt_if.evt_code, evt_if.evt_make);
      end else begin
        mon_e = exp_q.pop_front();
        if ({evt_if.evt_code, evt_if.evt_make} !== mon_e) begin
          n_bad++;
          $display("FAIL event: got code %03h make %0b required code %03h make %0b",
                   evt_if.evt_code, evt_if.evt_make, mon_e.code, mon_e.make);
        end else begin
          $display("event code=%03h make=%0b ok", evt_if.evt_code, evt_if.evt_make);
        end
      end
    end
  end

  // Drives one byte for one cycle; returns #1 after the sampling edge.
  task automatic send(input logic [7:0] b, input logic ok, input bit expect_ev,
                      input logic [8:0] c, input logic m);
    din           = b;
    din_parity_ok = ok;
    din_new       = 1'b1;
    if (expect_ev) exp_q.push_back({c, m});
    @(posedge clk);
    #1;
    din_new = 1'b0;
  endtask

  task automatic do_reset();
    resetN = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    resetN = 1'b1;
  endtask

  task automatic drain_check(input string name);
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    check({name, "_drained"}, exp_q.size(), 0);
    @(negedge clk);
    check({name, "_valid_low"}, evt_if.evt_valid, 1'b0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetN           = 1'b0;
    din              = 8'h00;
    din_new          = 1'b0;
    din_parity_ok    = 1'b1;
    evt_if.evt_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", evt_if.evt_valid, 1'b0);
    check("rst_code", evt_if.evt_code, 9'h000);
    check("rst_make", evt_if.evt_make, 1'b0);
    check("rst_held", key_held, 4'h0);
    check("rst_err", err_cnt, 8'd0);
    check("rst_ovf", evt_ovf, 1'b0);
    resetN = 1'b1;
    @(posedge clk);
    #1;

    // Space press and release.
    evt_if.evt_ready = 1'b1;
    send(8'h29, 1'b1, 1, 9'h029, 1'b1);
    check("space_held_set", key_held, 4'b0001);
    send(8'hF0, 1'b1, 0, 9'h000, 1'b0);
    send(8'h29, 1'b1, 1, 9'h029, 1'b0);
    check("space_held_clr", key_held, 4'b0000);
    drain_check("space");

    // Extended down press and release; prefixes produce nothing.
    send(8'hE0, 1'b1, 0, 9'h000, 1'b0);
    send(8'h72, 1'b1, 1, 9'h172, 1'b1);
    check("down_held_set", key_held, 4'b1000);
    send(8'hE0, 1'b1, 0, 9'h000, 1'b0);
    send(8'hF0, 1'b1, 0, 9'h000, 1'b0);
    send(8'h72, 1'b1, 1, 9'h172, 1'b0);
    check("down_held_clr", key_held, 4'b0000);
    drain_check("down");

    // Prefix timeout: the 1C after the gap must not be extended.
    send(8'hE0, 1'b1, 0, 9'h000, 1'b0);
    repeat (TMO + 2) @(posedge clk);
    #1;
    send(8'h1C, 1'b1, 1, 9'h01C, 1'b1);
    drain_check("timeout");

    // Parity errors saturate the counter and reset a pending prefix.
    for (int i = 0; i < 300; i++) send(8'h1C, 1'b0, 0, 9'h000, 1'b0);
    check("err_sat", err_cnt, 8'd255);
    send(8'hE0, 1'b1, 0, 9'h000, 1'b0);
    send(8'h1C, 1'b0, 0, 9'h000, 1'b0);
    send(8'h1C, 1'b1, 1, 9'h01C, 1'b1);
    check("err_hold", err_cnt, 8'd255);
    drain_check("parity");

    // Left held, then reset mid-prefix clears everything.
    send(8'hE0, 1'b1, 0, 9'h000, 1'b0);
    send(8'h6B, 1'b1, 1, 9'h16B, 1'b1);
    check("left_held_set", key_held, 4'b0010);
    @(posedge clk);
    #1;
    send(8'hE0, 1'b1, 0, 9'h000, 1'b0);
    do_reset();
    check("mid_rst_held", key_held, 4'h0);
    check("mid_rst_err", err_cnt, 8'd0);
    send(8'h1C, 1'b1, 1, 9'h01C, 1'b1);
    drain_check("mid_rst");

    // Overflow: six makes into a stalled FIFO; first four survive.
    do_reset();
    evt_if.evt_ready = 1'b0;
    send(8'h15, 1'b1, 1, 9'h015, 1'b1);
    send(8'h16, 1'b1, 1, 9'h016, 1'b1);
    send(8'h1E, 1'b1, 1, 9'h01E, 1'b1);
    send(8'h26, 1'b1, 1, 9'h026, 1'b1);
    check("full_no_ovf", evt_ovf, 1'b0);
    send(8'h25, 1'b1, 0, 9'h000, 1'b0);
    send(8'h2E, 1'b1, 0, 9'h000, 1'b0);
    check("ovf_set", evt_ovf, 1'b1);
    check("stall_valid", evt_if.evt_valid, 1'b1);
    check("stall_head", evt_if.evt_code, 9'h015);
    evt_if.evt_ready = 1'b1;
    drain_check("ovf");
    check("ovf_sticky", evt_ovf, 1'b1);

    // Full FIFO with simultaneous push and pop.
    do_reset();
    evt_if.evt_ready = 1'b0;
    send(8'hAA, 1'b1, 0, 9'h000, 1'b0);
    send(8'hFA, 1'b1, 0, 9'h000, 1'b0);
    send(8'h15, 1'b1, 1, 9'h015, 1'b1);
    send(8'h16, 1'b1, 1, 9'h016, 1'b1);
    send(8'h1E, 1'b1, 1, 9'h01E, 1'b1);
    send(8'h26, 1'b1, 1, 9'h026, 1'b1);
    evt_if.evt_ready = 1'b1;
    send(8'h2E, 1'b1, 1, 9'h02E, 1'b1);
    evt_if.evt_ready = 1'b0;
    check("pushpop_no_ovf", evt_ovf, 1'b0);
    check("pushpop_head", evt_if.evt_code, 9'h016);
    send(8'h25, 1'b1, 0, 9'h000, 1'b0);
    check("pushpop_still_full", evt_ovf, 1'b1);
    evt_if.evt_ready = 1'b1;
    drain_check("pushpop");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
